// File: rtl/udp_send_mux_pkg.sv
// Shared definitions for the UDP transmit framer: header size, default
// payload limit, FSM state encoding and the header byte selector.
package udp_send_mux_pkg;

    localparam int UDP_HDR_LEN     = 8;
    localparam int MAX_LEN_DEFAULT = 1472;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_OFFER = 3'd2,
        ST_HDR   = 3'd3,
        ST_PAY   = 3'd4
    } state_t;

    // Byte idx of the 8-byte UDP header, fields MSB first; checksum is zero.
    function automatic logic [7:0] hdr_byte(input logic [15:0] src_port,
                                            input logic [15:0] dst_port,
                                            input logic [15:0] udp_len,
                                            input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = src_port[15:8];
            3'd1:    b = src_port[7:0];
            3'd2:    b = dst_port[15:8];
            3'd3:    b = dst_port[7:0];
            3'd4:    b = udp_len[15:8];
            3'd5:    b = udp_len[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/udp_send_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer
// and moves the pointer past the winner when advance is pulsed.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;
    logic          found;
    int            idx;

    // Scan requesters starting at the pointer, wrapping past N-1.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            cand = IW'(idx);
            if (!found && req[cand]) begin
                found           = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = cand;
            end
        end
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
        end
    end

    // Pointer register; channel 0 has top priority out of reset.
    // NOTE: reset is synchronous active-low, so it lives inside the clocked block,
    //       and flops use non-blocking assignments so all see pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/udp_send_mux.sv
// Multi-channel UDP transmit framer: picks a channel round-robin, offers the
// packet length to the IP layer, then streams the UDP header and the
// channel's payload one byte per clock. ch_data is the head of the channel
// FIFO; the byte present while ch_rd is high is captured into data_out on
// that edge and the FIFO advances.
module udp_send_mux
    import udp_send_mux_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [15:0]          local_port,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [16*NUM_CH-1:0] ch_length,
    input  logic [8*NUM_CH-1:0]  ch_port_id,
    input  logic [16*NUM_CH-1:0] ch_dest_port,
    input  logic [8*NUM_CH-1:0]  ch_data,
    output logic [NUM_CH-1:0]    ch_rd,
    output logic [NUM_CH-1:0]    ch_grant,
    output logic                 pkt_ready,
    input  logic                 tx_go,
    output logic                 active,
    output logic [7:0]           data_out,
    output logic [15:0]          length_out,
    output logic                 len_err
);

    localparam int          IW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);
    localparam logic [15:0] HDR_LEN16 = 16'(UDP_HDR_LEN);

    // Per-channel views of the flattened input buses.
    logic [15:0] len_arr  [NUM_CH];
    logic [7:0]  port_arr [NUM_CH];
    logic [15:0] dst_arr  [NUM_CH];
    logic [7:0]  data_arr [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign len_arr[i]  = ch_length[i*16 +: 16];
        assign port_arr[i] = ch_port_id[i*8 +: 8];
        assign dst_arr[i]  = ch_dest_port[i*16 +: 16];
        assign data_arr[i] = ch_data[i*8 +: 8];
    end

    state_t              state_q, state_d;
    logic [IW-1:0]       sel_q, sel_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [NUM_CH-1:0]   rd_q, rd_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         pay_len_q, pay_len_d;
    logic [15:0]         src_port_q, src_port_d;
    logic [15:0]         dst_port_q, dst_port_d;
    logic [15:0]         length_out_q, length_out_d;
    logic                pkt_ready_q, pkt_ready_d;
    logic                active_q, active_d;
    logic [7:0]          data_out_q, data_out_d;
    logic                len_err_q, len_err_d;

    logic [15:0]         req_len;
    logic [15:0]         clamp_len;
    logic                last_pay;
    logic                arb_advance;
    logic [NUM_CH-1:0]   arb_grant;
    logic [IW-1:0]       arb_idx;

    // The pointer moves on the cycle that commits a grant into ARB.
    assign arb_advance = (state_q == ST_IDLE) && (|ch_req);

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (IW)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (ch_req),
        .advance   (arb_advance),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Next-state, latches and output stream for the framing FSM.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        grant_d      = grant_q;
        rd_d         = '0;
        cnt_d        = cnt_q;
        pay_len_d    = pay_len_q;
        src_port_d   = src_port_q;
        dst_port_d   = dst_port_q;
        length_out_d = length_out_q;
        pkt_ready_d  = pkt_ready_q;
        active_d     = active_q;
        data_out_d   = data_out_q;
        len_err_d    = 1'b0;
        req_len      = len_arr[sel_q];
        clamp_len    = req_len;
        last_pay     = (cnt_q + 16'd1) >= pay_len_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|ch_req) begin
                    state_d = ST_ARB;
                    sel_d   = arb_idx;
                    grant_d = arb_grant;
                end
            end

            ST_ARB: begin
                if (req_len > MAX_LEN16) begin
                    clamp_len = MAX_LEN16;
                    len_err_d = 1'b1;
                end
                pay_len_d    = clamp_len;
                length_out_d = clamp_len + HDR_LEN16;
                src_port_d   = local_port + {8'd0, port_arr[sel_q]};
                dst_port_d   = dst_arr[sel_q];
                pkt_ready_d  = 1'b1;
                state_d      = ST_OFFER;
            end

            ST_OFFER: begin
                if (tx_go) begin
                    state_d     = ST_HDR;
                    pkt_ready_d = 1'b0;
                    active_d    = 1'b1;
                    cnt_d       = '0;
                    data_out_d  = hdr_byte(src_port_q, dst_port_q, length_out_q, 3'd0);
                end
            end

            ST_HDR: begin
                // cnt_q[2:0] is the header byte currently on data_out.
                if (cnt_q[2:0] != 3'd7) begin
                    cnt_d      = cnt_q + 16'd1;
                    data_out_d = hdr_byte(src_port_q, dst_port_q, length_out_q,
                                          cnt_q[2:0] + 3'd1);
                    if (cnt_q[2:0] == 3'd6 && pay_len_q != 16'd0) rd_d = grant_q;
                end else if (pay_len_q == 16'd0) begin
                    state_d    = ST_IDLE;
                    active_d   = 1'b0;
                    grant_d    = '0;
                    data_out_d = 8'h00;
                end else begin
                    state_d    = ST_PAY;
                    cnt_d      = '0;
                    data_out_d = data_arr[sel_q];
                    if (pay_len_q > 16'd1) rd_d = grant_q;
                end
            end

            ST_PAY: begin
                // cnt_q is the payload byte currently on data_out.
                if (!last_pay) begin
                    cnt_d      = cnt_q + 16'd1;
                    data_out_d = data_arr[sel_q];
                    if ((cnt_q + 16'd2) < pay_len_q) rd_d = grant_q;
                end else begin
                    state_d    = ST_IDLE;
                    active_d   = 1'b0;
                    grant_d    = '0;
                    data_out_d = 8'h00;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            grant_q      <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            pay_len_q    <= '0;
            src_port_q   <= '0;
            dst_port_q   <= '0;
            length_out_q <= '0;
            pkt_ready_q  <= 1'b0;
            active_q     <= 1'b0;
            data_out_q   <= 8'h00;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            grant_q      <= grant_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            pay_len_q    <= pay_len_d;
            src_port_q   <= src_port_d;
            dst_port_q   <= dst_port_d;
            length_out_q <= length_out_d;
            pkt_ready_q  <= pkt_ready_d;
            active_q     <= active_d;
            data_out_q   <= data_out_d;
            len_err_q    <= len_err_d;
        end
    end

    assign ch_rd      = rd_q;
    assign ch_grant   = grant_q;
    assign pkt_ready  = pkt_ready_q;
    assign active     = active_q;
    assign data_out   = data_out_q;
    assign length_out = length_out_q;
    assign len_err    = len_err_q;

endmodule
